acq_capture_ctrl: RTL and testbench

- Acquisition sequencer for the scope's sample RAM. Writes a frame of ADC samples circularly with pre-trigger history.
- Detects a level/slope trigger, or forces one in auto mode, then completes the post-trigger portion.
- Flags the frame ready for the display reader and holds it until the reader acknowledges.
- Frame length follows the sampling mode: 200 points in single-trace mode, 400 points in dual-trace mode.

---
 rtl/acq_capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_acq_capture_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/acq_capture_ctrl.sv
// Acquisition sequencer: circular frame capture into sample RAM with pre-trigger
// history, level/slope or auto trigger, and a frame-ready handshake with the display.
module acq_capture_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int AUTO_TO = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              sample_type,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              auto_trig,
  input  logic              disp_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              frame_ready,
  output logic              busy
);

  localparam int TO_W = $clog2(AUTO_TO + 1);
  localparam logic [ADDR_W-1:0] LAST_SINGLE = ADDR_W'(199);
  localparam logic [ADDR_W-1:0] LAST_DUAL   = ADDR_W'(399);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READY} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_n_last;
  logic [ADDR_W-1:0] r_p;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_vld;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_start_addr;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  logic [ADDR_W-1:0] w_n_last;
  logic [ADDR_W-1:0] w_p;
  logic              w_active;
  logic              w_accept;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic [ADDR_W-1:0] w_post_len;
  logic [ADDR_W:0]   w_wrap_sum;
  logic [ADDR_W-1:0] w_start;
  logic              w_rise;
  logic              w_fall;
  logic              w_auto;
  logic              w_trig;

  assign w_n_last   = sample_type ? LAST_DUAL : LAST_SINGLE;
  assign w_p        = (pre_len > w_n_last) ? w_n_last : pre_len;
  assign w_active   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_accept   = sample_en && w_active && !arm;
  assign w_ptr_nxt  = (r_wr_ptr == r_n_last) ? '0 : r_wr_ptr + 1'b1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_post_len = r_n_last - r_p;

  // Pre-trigger start wraps backwards through the frame: trig + N - P when trig < P.
  assign w_wrap_sum = {1'b0, r_wr_ptr} + {1'b0, r_n_last} + (ADDR_W + 1)'(1) - {1'b0, r_p};
  assign w_start    = (r_wr_ptr >= r_p) ? (r_wr_ptr - r_p) : w_wrap_sum[ADDR_W-1:0];

  assign w_rise = trig_slope && (r_prev < trig_level) && (adc_data >= trig_level);
  assign w_fall = !trig_slope && (r_prev > trig_level) && (adc_data <= trig_level);
  assign w_auto = auto_trig && (r_to_cnt >= TO_W'(AUTO_TO - 1));
  assign w_trig = (r_state == S_WAIT) && w_accept && r_prev_vld && (w_rise || w_fall || w_auto);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = (w_p != '0) ? S_PRE : S_WAIT;
    end else begin
      case (r_state)
        S_PRE:   if (w_accept && (w_cnt_inc == r_p)) w_state_nxt = S_WAIT;
        S_WAIT:  if (w_trig) w_state_nxt = (w_post_len == '0) ? S_READY : S_POST;
        S_POST:  if (w_accept && (r_post_cnt == ADDR_W'(1))) w_state_nxt = S_READY;
        S_READY: if (disp_ack) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_n_last     <= '0;
      r_p          <= '0;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_post_cnt   <= '0;
      r_to_cnt     <= '0;
      r_prev_vld   <= 1'b0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_ram_we <= w_accept;
      if (w_accept) begin
        r_ram_addr  <= r_wr_ptr;
        r_ram_wdata <= adc_data;
      end
      if (arm) begin
        r_n_last   <= w_n_last;
        r_p        <= w_p;
        r_wr_ptr   <= '0;
        r_cnt      <= '0;
        r_to_cnt   <= '0;
        r_prev_vld <= 1'b0;
      end else if (w_accept) begin
        r_wr_ptr <= w_ptr_nxt;
        case (r_state)
          S_PRE: begin
            r_cnt      <= w_cnt_inc;
            r_prev_vld <= 1'b1;
          end
          S_WAIT: begin
            r_prev_vld <= 1'b1;
            if (r_to_cnt < TO_W'(AUTO_TO)) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_trig) begin
              r_trig_addr  <= r_wr_ptr;
              r_start_addr <= w_start;
              r_post_cnt   <= w_post_len;
            end
          end
          S_POST:  r_post_cnt <= r_post_cnt - 1'b1;
          default: r_post_cnt <= r_post_cnt;
        endcase
      end
    end
  end

  // Previous-sample history is pure data; its validity flag above gates its use.
  always_ff @(posedge clock) begin
    if (w_accept && ((r_state == S_PRE) || (r_state == S_WAIT))) r_prev <= adc_data;
  end

  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign trig_addr   = r_trig_addr;
  assign start_addr  = r_start_addr;
  assign frame_ready = (r_state == S_READY);
  assign busy        = w_active;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Directed bench for acq_capture_ctrl: expected RAM writes go into a scoreboard
// queue drained by a monitor branch; status outputs are checked against hand values.
module tb_acq_capture_ctrl;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int AUTO_TO = 1023;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              arm;
  logic              sample_type;
  logic [ADDR_W-1:0] pre_len;
  logic              sample_en;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              auto_trig;
  logic              disp_ack;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              frame_ready;
  logic              busy;

  always #5 clock = ~clock;

  acq_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_TO(AUTO_TO)) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm), .sample_type(sample_type),
    .pre_len(pre_len), .sample_en(sample_en), .adc_data(adc_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .auto_trig(auto_trig),
    .disp_ack(disp_ack), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .start_addr(start_addr), .trig_addr(trig_addr), .frame_ready(frame_ready), .busy(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_ptr = 0;
  int  exp_n = 200;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_arm(input bit st, input logic [ADDR_W-1:0] pl, input bit with_sample);
    arm = 1'b1; sample_type = st; pre_len = pl;
    sample_en = with_sample; adc_data = 8'hAA;
    exp_n = st ? 400 : 200;
    exp_ptr = 0;
    @(posedge clock); #1;
    arm = 1'b0; sample_en = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit expect_wr);
    wr_t e;
    sample_en = 1'b1; adc_data = d;
    if (expect_wr) begin
      e.addr = ADDR_W'(exp_ptr);
      e.data = d;
      sb_q.push_back(e);
      exp_ptr = (exp_ptr == exp_n - 1) ? 0 : exp_ptr + 1;
    end
    @(posedge clock); #1;
    sample_en = 1'b0;
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    @(posedge clock); #1;
    disp_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; sample_type = 1'b0; pre_len = '0;
    sample_en = 1'b0; adc_data = '0; trig_level = 8'd100; trig_slope = 1'b1;
    auto_trig = 1'b0; disp_ack = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (reset_n && ram_we) begin
          wr_t e;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0d, no write expected", ram_addr, ram_wdata);
          end else begin
            e = sb_q.pop_front();
            if (ram_addr !== e.addr || ram_wdata !== e.data) begin
              errors++;
              $display("FAIL ram_write: got addr %0d data %0d, expected addr %0d data %0d",
                       ram_addr, ram_wdata, e.addr, e.data);
            end
          end
        end
      end
    join_none

    #2;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Single trace, 50 pre-trigger samples, rising at 100 on a repeating ramp
    trig_level = 8'd100; trig_slope = 1'b1;
    do_arm(1'b0, 9'd50, 1'b0);
    chk("t1_busy_after_arm", busy, 1);
    for (int i = 0; i < 250; i++) send(DATA_W'(i % 256), 1'b1);
    chk("t1_frame_ready", frame_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_trig_addr", trig_addr, 100);
    chk("t1_start_addr", start_addr, 50);
    send(8'd33, 1'b0);
    send(8'd34, 1'b0);
    chk("t1_ready_held", frame_ready, 1);
    ack();
    chk("t1_ack_frame_ready", frame_ready, 0);
    chk("t1_ack_busy", busy, 0);

    // Dual trace, no pre-trigger; first sample has no history and must not trigger
    do_arm(1'b1, 9'd0, 1'b0);
    chk("t2_busy", busy, 1);
    send(8'd150, 1'b1);
    send(8'd50, 1'b1);
    send(8'd120, 1'b1);
    chk("t2_trig_addr", trig_addr, 2);
    chk("t2_start_addr", start_addr, 2);
    for (int i = 0; i < 398; i++) send(DATA_W'((i * 3) % 256), 1'b1);
    chk("t2_not_ready_early", frame_ready, 0);
    send(8'd9, 1'b1);
    chk("t2_frame_ready", frame_ready, 1);
    ack();
    chk("t2_ack_frame_ready", frame_ready, 0);

    // Auto trigger on the 1023rd waiting sample of a flat signal
    auto_trig = 1'b1;
    do_arm(1'b0, 9'd0, 1'b0);
    for (int i = 0; i < 1022; i++) send(8'd20, 1'b1);
    chk("t3_no_early_auto", busy, 1);
    send(8'd20, 1'b1);
    chk("t3_auto_trig_addr", trig_addr, 22);
    chk("t3_auto_start_addr", start_addr, 22);
    for (int i = 0; i < 199; i++) send(8'd20, 1'b1);
    chk("t3_frame_ready", frame_ready, 1);
    ack();

    // Without auto trigger the capture waits indefinitely; then reset mid-write
    auto_trig = 1'b0;
    do_arm(1'b0, 9'd0, 1'b0);
    for (int i = 0; i < 1100; i++) send(8'd20, 1'b1);
    chk("t3b_still_busy", busy, 1);
    chk("t3b_no_ready", frame_ready, 0);
    send(8'd21, 1'b1);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("t3b_async_ram_we", ram_we, 0);
    chk("t3b_async_busy", busy, 0);
    chk("t3b_async_ram_addr", ram_addr, 0);
    chk("t3b_async_trig_addr", trig_addr, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("t3b_no_pending_write", ram_we, 0);

    // Oversized pre_len clamps to N-1: trigger goes straight to READY
    trig_level = 8'd250; trig_slope = 1'b1;
    do_arm(1'b0, 9'd500, 1'b0);
    for (int i = 0; i < 199; i++) send(DATA_W'(i), 1'b1);
    for (int i = 0; i < 5; i++) send(8'd10, 1'b1);
    chk("t4_waiting", frame_ready, 0);
    send(8'd255, 1'b1);
    chk("t4_frame_ready", frame_ready, 1);
    chk("t4_trig_addr", trig_addr, 4);
    chk("t4_start_addr", start_addr, 5);
    send(8'd77, 1'b0);
    ack();

    // Falling trigger, re-arm mid-POST with a colliding sample, ignored disp_ack
    trig_level = 8'd128; trig_slope = 1'b0;
    do_arm(1'b0, 9'd2, 1'b0);
    send(8'd200, 1'b1);
    send(8'd200, 1'b1);
    send(8'd200, 1'b1);
    send(8'd200, 1'b1);
    send(8'd50, 1'b1);
    chk("t5_trig_addr", trig_addr, 4);
    chk("t5_start_addr", start_addr, 2);
    for (int i = 0; i < 10; i++) send(8'd90, 1'b1);
    do_arm(1'b0, 9'd0, 1'b1);
    chk("t5_rearm_busy", busy, 1);
    chk("t5_rearm_frame_ready", frame_ready, 0);
    send(8'd7, 1'b1);
    ack();
    chk("t5_ack_ignored", busy, 1);
    send(8'd200, 1'b1);
    send(8'd100, 1'b1);
    chk("t5b_trig_addr", trig_addr, 2);
    chk("t5b_start_addr", start_addr, 2);
    for (int i = 0; i < 199; i++) send(8'd60, 1'b1);
    chk("t5b_frame_ready", frame_ready, 1);
    ack();
    chk("t5b_ack_frame_ready", frame_ready, 0);
    chk("t5b_ack_busy", busy, 0);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
